// File: rtl/ulpi_reg_arbiter.sv
// Shares the ULPI PHY register port between two requesters after a boot-time init write.
// Accesses are strobed, retried on PHY abort, timed out, and acknowledged back to the owner.
module ulpi_reg_arbiter #(
    parameter logic [5:0] INIT_ADDR = 6'h04,
    parameter logic [7:0] INIT_DATA = 8'h45,
    parameter int         MAX_RETRY = 3,
    parameter int         TIMEOUT   = 255
) (
    input  logic       CLK_60M,
    input  logic       NRST_A_USB,
    input  logic       R0_REQ,
    input  logic       R0_RW,
    input  logic [5:0] R0_ADDR,
    input  logic [7:0] R0_WDATA,
    output logic [7:0] R0_RDATA,
    output logic       R0_ACK,
    output logic       R0_ERR,
    input  logic       R1_REQ,
    input  logic       R1_RW,
    input  logic [5:0] R1_ADDR,
    input  logic [7:0] R1_WDATA,
    output logic [7:0] R1_RDATA,
    output logic       R1_ACK,
    output logic       R1_ERR,
    output logic       REG_RW,
    output logic       REG_EN,
    output logic [5:0] REG_ADDR,
    output logic [7:0] REG_DATA_I,
    input  logic [7:0] REG_DATA_O,
    input  logic       REG_DONE,
    input  logic       REG_FAIL,
    input  logic       READY,
    output logic       INIT_DONE,
    output logic       INIT_ERR
);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_BOOT_WAIT, S_ISSUE, S_WAIT, S_GAP, S_GAP_RDY, S_COMPLETE, S_GAP_ARB, S_ARB
    } state_t;

    state_t               state_q, state_d;
    logic                 rdy_seen_q, rdy_seen_d;
    logic                 boot_q, boot_d;
    logic                 owner_q, owner_d;
    logic                 rr_q, rr_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [7:0]           timer_q, timer_d;
    logic                 err_q, err_d;
    logic [7:0]           cap_q, cap_d;
    logic                 acc_rw_q, acc_rw_d;
    logic [5:0]           acc_addr_q, acc_addr_d;
    logic [7:0]           acc_data_q, acc_data_d;
    logic                 reg_en_q, reg_en_d;
    logic                 r0_ack_q, r0_ack_d, r0_err_q, r0_err_d;
    logic [7:0]           r0_rdata_q, r0_rdata_d;
    logic                 r1_ack_q, r1_ack_d, r1_err_q, r1_err_d;
    logic [7:0]           r1_rdata_q, r1_rdata_d;
    logic                 init_done_q, init_done_d, init_err_q, init_err_d;
    logic                 grant1;

    always_comb begin
        state_d     = state_q;
        rdy_seen_d  = rdy_seen_q;
        boot_d      = boot_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        retry_d     = retry_q;
        timer_d     = timer_q;
        err_d       = err_q;
        cap_d       = cap_q;
        acc_rw_d    = acc_rw_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        r0_err_d    = r0_err_q;
        r0_rdata_d  = r0_rdata_q;
        r1_err_d    = r1_err_q;
        r1_rdata_d  = r1_rdata_q;
        init_done_d = init_done_q;
        init_err_d  = init_err_q;
        r0_ack_d    = 1'b0;
        r1_ack_d    = 1'b0;
        grant1      = R1_REQ && (!R0_REQ || rr_q);

        case (state_q)
            S_BOOT_WAIT: begin
                rdy_seen_d = READY;
                if (READY && rdy_seen_q) begin
                    acc_rw_d   = 1'b1;
                    acc_addr_d = INIT_ADDR;
                    acc_data_d = INIT_DATA;
                    boot_d     = 1'b1;
                    retry_d    = '0;
                    cap_d      = 8'd0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // timer_q counts cycles since the strobe, so ACK lands exactly TIMEOUT cycles after it
                timer_d = 8'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (REG_DONE) begin
                    err_d = 1'b0;
                    if (!acc_rw_q) cap_d = REG_DATA_O;
                    state_d = S_COMPLETE;
                end else if (REG_FAIL) begin
                    if (32'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = S_GAP;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_COMPLETE;
                    end
                end else if (timer_d == 8'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_COMPLETE;
                end
            end
            S_GAP:     state_d = S_GAP_RDY;
            S_GAP_RDY: if (READY) state_d = S_ISSUE;
            S_COMPLETE: begin
                if (boot_q) begin
                    init_done_d = 1'b1;
                    init_err_d  = init_err_q | err_q;
                    boot_d      = 1'b0;
                end else begin
                    rr_d = ~owner_q;
                end
                state_d = S_GAP_ARB;
            end
            S_GAP_ARB: state_d = S_ARB;
            S_ARB: begin
                if (init_done_q && READY && (R0_REQ || R1_REQ)) begin
                    owner_d    = grant1;
                    acc_rw_d   = grant1 ? R1_RW    : R0_RW;
                    acc_addr_d = grant1 ? R1_ADDR  : R0_ADDR;
                    acc_data_d = grant1 ? R1_WDATA : R0_WDATA;
                    retry_d    = '0;
                    cap_d      = 8'd0;
                    state_d    = S_ISSUE;
                end
            end
            default: state_d = S_BOOT_WAIT;
        endcase

        reg_en_d = (state_d == S_ISSUE);
        // Requester results are published in the COMPLETE cycle, alongside the ACK pulse
        if (state_d == S_COMPLETE && !boot_q) begin
            if (owner_q) begin
                r1_ack_d   = 1'b1;
                r1_err_d   = err_d;
                r1_rdata_d = cap_d;
            end else begin
                r0_ack_d   = 1'b1;
                r0_err_d   = err_d;
                r0_rdata_d = cap_d;
            end
        end
    end

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state_q     <= S_BOOT_WAIT;
            rdy_seen_q  <= 1'b0;
            boot_q      <= 1'b0;
            owner_q     <= 1'b0;
            rr_q        <= 1'b0;
            retry_q     <= '0;
            timer_q     <= 8'd0;
            err_q       <= 1'b0;
            cap_q       <= 8'd0;
            acc_rw_q    <= 1'b0;
            acc_addr_q  <= 6'd0;
            acc_data_q  <= 8'd0;
            reg_en_q    <= 1'b0;
            r0_ack_q    <= 1'b0;
            r0_err_q    <= 1'b0;
            r0_rdata_q  <= 8'd0;
            r1_ack_q    <= 1'b0;
            r1_err_q    <= 1'b0;
            r1_rdata_q  <= 8'd0;
            init_done_q <= 1'b0;
            init_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdy_seen_q  <= rdy_seen_d;
            boot_q      <= boot_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            retry_q     <= retry_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            cap_q       <= cap_d;
            acc_rw_q    <= acc_rw_d;
            acc_addr_q  <= acc_addr_d;
            acc_data_q  <= acc_data_d;
            reg_en_q    <= reg_en_d;
            r0_ack_q    <= r0_ack_d;
            r0_err_q    <= r0_err_d;
            r0_rdata_q  <= r0_rdata_d;
            r1_ack_q    <= r1_ack_d;
            r1_err_q    <= r1_err_d;
            r1_rdata_q  <= r1_rdata_d;
            init_done_q <= init_done_d;
            init_err_q  <= init_err_d;
        end
    end

    assign REG_EN     = reg_en_q;
    assign REG_RW     = acc_rw_q;
    assign REG_ADDR   = acc_addr_q;
    assign REG_DATA_I = acc_data_q;
    assign R0_ACK     = r0_ack_q;
    assign R0_ERR     = r0_err_q;
    assign R0_RDATA   = r0_rdata_q;
    assign R1_ACK     = r1_ack_q;
    assign R1_ERR     = r1_err_q;
    assign R1_RDATA   = r1_rdata_q;
    assign INIT_DONE  = init_done_q;
    assign INIT_ERR   = init_err_q;
endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: scripted PHY responder, two requester drivers, and a
// transaction-level model predicting strobe count, payload and ACK result per access.
module tb_ulpi_reg_arbiter;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 255;

    logic       clk = 1'b0;
    logic       nrst;
    logic       r0_req, r0_rw, r0_ack, r0_err;
    logic [5:0] r0_addr;
    logic [7:0] r0_wdata, r0_rdata;
    logic       r1_req, r1_rw, r1_ack, r1_err;
    logic [5:0] r1_addr;
    logic [7:0] r1_wdata, r1_rdata;
    logic       reg_rw, reg_en, reg_done, reg_fail, ready, init_done, init_err;
    logic [5:0] reg_addr;
    logic [7:0] reg_data_i, reg_data_o;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    bit abort = 1'b0;

    typedef struct { int cyc; logic rw; logic [5:0] addr; logic [7:0] data; } strobe_t;
    typedef struct { int cyc; int who; logic err; logic [7:0] rdata; } ack_t;
    typedef struct { int fails; bit answer; int lat; logic [7:0] rd; } phy_t;
    typedef struct { logic rw; logic [5:0] addr; logic [7:0] wd; } op_t;

    strobe_t st_log[$];
    ack_t    ack_log[$];
    phy_t    phy_q[$];
    op_t     op0_q[$];
    op_t     op1_q[$];

    ulpi_reg_arbiter dut (
        .CLK_60M(clk), .NRST_A_USB(nrst),
        .R0_REQ(r0_req), .R0_RW(r0_rw), .R0_ADDR(r0_addr), .R0_WDATA(r0_wdata),
        .R0_RDATA(r0_rdata), .R0_ACK(r0_ack), .R0_ERR(r0_err),
        .R1_REQ(r1_req), .R1_RW(r1_rw), .R1_ADDR(r1_addr), .R1_WDATA(r1_wdata),
        .R1_RDATA(r1_rdata), .R1_ACK(r1_ack), .R1_ERR(r1_err),
        .REG_RW(reg_rw), .REG_EN(reg_en), .REG_ADDR(reg_addr), .REG_DATA_I(reg_data_i),
        .REG_DATA_O(reg_data_o), .REG_DONE(reg_done), .REG_FAIL(reg_fail), .READY(ready),
        .INIT_DONE(init_done), .INIT_ERR(init_err)
    );

    always #8 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        strobe_t s;
        ack_t    a;
        if (reg_en) begin
            s.cyc = cyc; s.rw = reg_rw; s.addr = reg_addr; s.data = reg_data_i;
            st_log.push_back(s);
        end
        if (r0_ack) begin
            a.cyc = cyc; a.who = 0; a.err = r0_err; a.rdata = r0_rdata;
            ack_log.push_back(a);
        end
        if (r1_ack) begin
            a.cyc = cyc; a.who = 1; a.err = r1_err; a.rdata = r1_rdata;
            ack_log.push_back(a);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {26'd0, r0_rdata, r0_ack, r0_err, r1_rdata, r1_ack, r1_err,
                reg_rw, reg_en, reg_addr, reg_data_i, init_done, init_err};
    endfunction

    function automatic phy_t mk(input int f, input bit a, input int l, input logic [7:0] r);
        phy_t p;
        p.fails = f; p.answer = a; p.lat = l; p.rd = r;
        return p;
    endfunction

    task automatic wait_strobe();
        do @(negedge clk); while (!reg_en);
    endtask

    task automatic pulse(input bit done, input int lat, input logic [7:0] rd);
        repeat (lat) @(negedge clk);
        reg_done = done; reg_fail = !done; reg_data_o = rd;
        @(negedge clk);
        reg_done = 1'b0; reg_fail = 1'b0;
    endtask

    // PHY responder: each script entry serves one whole access
    initial begin
        phy_t p;
        reg_done = 1'b0; reg_fail = 1'b0; reg_data_o = 8'd0;
        forever begin
            while (phy_q.size() == 0) @(negedge clk);
            p = phy_q.pop_front();
            for (int i = 0; i < p.fails; i++) begin
                wait_strobe();
                pulse(1'b0, p.lat, 8'd0);
            end
            if (p.answer) begin
                wait_strobe();
                pulse(1'b1, p.lat, p.rd);
            end
        end
    end

    task automatic run_req(input int who);
        op_t o;
        forever begin
            @(negedge clk);
            if (who == 0 && op0_q.size() > 0) begin
                o = op0_q.pop_front();
                r0_rw = o.rw; r0_addr = o.addr; r0_wdata = o.wd; r0_req = 1'b1;
                while (!r0_ack && !abort) @(negedge clk);
                r0_req = 1'b0;
            end else if (who == 1 && op1_q.size() > 0) begin
                o = op1_q.pop_front();
                r1_rw = o.rw; r1_addr = o.addr; r1_wdata = o.wd; r1_req = 1'b1;
                while (!r1_ack && !abort) @(negedge clk);
                r1_req = 1'b0;
            end
        end
    endtask

    initial run_req(0);
    initial run_req(1);

    task automatic push_op(input int who, input logic rw, input logic [5:0] addr, input logic [7:0] wd);
        op_t o;
        o.rw = rw; o.addr = addr; o.wd = wd;
        if (who == 0) op0_q.push_back(o); else op1_q.push_back(o);
    endtask

    // One access end to end; the model predicts strobes and the ACK from the PHY script
    task automatic do_access(input string tag, input int who, input logic rw, input logic [5:0] addr,
                             input logic [7:0] wd, input int fails, input bit answer, input int lat,
                             input logic [7:0] rd);
        int s0, a0, t, n_exp;
        bit err_exp;
        logic [7:0] rd_exp;
        s0 = st_log.size();
        a0 = ack_log.size();
        n_exp   = (fails > MAX_RETRY) ? MAX_RETRY + 1 : fails + 1;
        err_exp = (fails > MAX_RETRY) || !answer;
        rd_exp  = (err_exp || rw) ? 8'd0 : rd;
        phy_q.push_back(mk((fails > MAX_RETRY) ? MAX_RETRY + 1 : fails,
                           answer && fails <= MAX_RETRY, lat, rd));
        push_op(who, rw, addr, wd);
        t = 0;
        while (ack_log.size() == a0 && t < 2000) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        chk($sformatf("%s_ack_count", tag), 64'(ack_log.size() - a0), 64'd1);
        chk($sformatf("%s_strobes", tag), 64'(st_log.size() - s0), 64'(n_exp));
        for (int i = 0; i < n_exp && s0 + i < st_log.size(); i++)
            chk($sformatf("%s_strobe%0d", tag, i),
                {st_log[s0+i].rw, st_log[s0+i].addr, st_log[s0+i].data}, {rw, addr, wd});
        if (ack_log.size() > a0)
            chk($sformatf("%s_ack", tag),
                {ack_log[a0].who[0], ack_log[a0].err, ack_log[a0].rdata}, {who[0], err_exp, rd_exp});
    endtask

    task automatic wait_boot(input string tag, input int s0);
        int t;
        t = 0;
        while (!init_done && t < 500) begin @(negedge clk); t++; end
        chk($sformatf("%s_init_done", tag), 64'(init_done), 64'd1);
        chk($sformatf("%s_init_err", tag), 64'(init_err), 64'd0);
        chk($sformatf("%s_strobes", tag), 64'(st_log.size() - s0), 64'd1);
        if (st_log.size() > s0)
            chk($sformatf("%s_payload", tag),
                {st_log[s0].rw, st_log[s0].addr, st_log[s0].data}, {1'b1, 6'h04, 8'h45});
    endtask

    initial begin
        int s0, a0, t, ptr, p0, p1, k, min_gap;
        int exp_who[$];
        logic [5:0] exp_addr[$];
        logic [5:0] a0_list[$];
        logic [5:0] a1_list[$];

        nrst = 1'b0; ready = 1'b1; abort = 1'b0;
        r0_req = 1'b0; r0_rw = 1'b0; r0_addr = 6'd0; r0_wdata = 8'd0;
        r1_req = 1'b0; r1_rw = 1'b0; r1_addr = 6'd0; r1_wdata = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);

        // Boot write answered 5 cycles after the strobe
        s0 = st_log.size();
        phy_q.push_back(mk(0, 1'b1, 5, 8'd0));
        nrst = 1'b1;
        wait_boot("boot", s0);

        do_access("r0_read", 0, 1'b0, 6'h16, 8'h00, 0, 1'b1, 4, 8'hA5);
        do_access("r1_retry", 1, 1'b1, 6'h0A, 8'h06, 2, 1'b1, 3, 8'h00);

        // Contention: both requesters hold two writes each
        @(posedge clk);
        s0 = st_log.size();
        a0 = ack_log.size();
        a0_list = '{6'h10, 6'h11};
        a1_list = '{6'h20, 6'h21};
        for (int i = 0; i < 4; i++) phy_q.push_back(mk(0, 1'b1, 3, 8'd0));
        for (int i = 0; i < 2; i++) begin
            push_op(0, 1'b1, a0_list[i], 8'(i));
            push_op(1, 1'b1, a1_list[i], 8'(i));
        end
        ptr = 0; p0 = 0; p1 = 0;
        for (int i = 0; i < 4; i++) begin
            k = (p0 < 2 && p1 < 2) ? ptr : (p0 < 2 ? 0 : 1);
            exp_who.push_back(k);
            exp_addr.push_back(k == 0 ? a0_list[p0] : a1_list[p1]);
            if (k == 0) p0++; else p1++;
            ptr = 1 - k;
        end
        t = 0;
        while (ack_log.size() < a0 + 4 && t < 3000) begin @(negedge clk); t++; end
        chk("contend_acks", 64'(ack_log.size() - a0), 64'd4);
        for (int i = 0; i < 4 && a0 + i < ack_log.size() && s0 + i < st_log.size(); i++) begin
            chk($sformatf("contend_who%0d", i), 64'(ack_log[a0+i].who), 64'(exp_who[i]));
            chk($sformatf("contend_addr%0d", i), 64'(st_log[s0+i].addr), 64'(exp_addr[i]));
        end

        do_access("r0_exhaust", 0, 1'b1, 6'h2B, 8'h99, 4, 1'b0, 2, 8'h00);
        do_access("r1_timeout", 1, 1'b0, 6'h33, 8'h00, 0, 1'b0, 1, 8'h00);
        if (st_log.size() > 0 && ack_log.size() > 0)
            chk("timeout_latency", 64'(ack_log[ack_log.size()-1].cyc - st_log[st_log.size()-1].cyc),
                64'(TIMEOUT));

        // READY low in ARB blocks the grant
        @(negedge clk);
        ready = 1'b0;
        s0 = st_log.size();
        a0 = ack_log.size();
        phy_q.push_back(mk(0, 1'b1, 2, 8'h5C));
        push_op(0, 1'b0, 6'h07, 8'h00);
        repeat (20) @(negedge clk);
        chk("ready_low_no_strobe", 64'(st_log.size() - s0), 64'd0);
        ready = 1'b1;
        t = 0;
        while (ack_log.size() == a0 && t < 500) begin @(negedge clk); t++; end
        chk("ready_high_ack", 64'(ack_log.size() - a0), 64'd1);
        if (ack_log.size() > a0)
            chk("ready_high_rdata", 64'({ack_log[a0].err, ack_log[a0].rdata}), 64'({1'b0, 8'h5C}));

        for (int i = 0; i < 10; i++)
            do_access($sformatf("rand%0d", i), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      6'($urandom_range(0, 63)), 8'($urandom_range(0, 255)),
                      int'($urandom_range(0, 4)), 1'b1, int'($urandom_range(1, 12)),
                      8'($urandom_range(0, 255)));

        // Reset while an R1 read is pending in WAIT
        s0 = st_log.size();
        a0 = ack_log.size();
        phy_q.push_back(mk(0, 1'b0, 1, 8'd0));
        push_op(1, 1'b0, 6'h1F, 8'h00);
        t = 0;
        while (st_log.size() == s0 && t < 500) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        abort = 1'b1;
        nrst = 1'b0;
        #1;
        chk("midreset_outputs", outs(), 64'd0);
        repeat (3) @(negedge clk);
        abort = 1'b0;
        s0 = st_log.size();
        phy_q.push_back(mk(0, 1'b1, 5, 8'd0));
        nrst = 1'b1;
        wait_boot("reboot", s0);
        chk("midreset_no_ack", 64'(ack_log.size() - a0), 64'd0);
        do_access("r1_rerequest", 1, 1'b0, 6'h1F, 8'h00, 0, 1'b1, 3, 8'hC3);

        min_gap = 1000;
        for (int i = 1; i < st_log.size(); i++)
            if (st_log[i].cyc - st_log[i-1].cyc < min_gap) min_gap = st_log[i].cyc - st_log[i-1].cyc;
        chk("strobe_gap_ge2", 64'(min_gap >= 2), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
